// File: rtl/run_sequencer_rv32.sv
// run_sequencer_rv32: run controller for an RV32 core. It sequences the core
// reset, shapes the core clock enable, counts run cycles and ends the run on a
// confirmed halt PC (pass) or when the cycle budget runs out (fail).
//
// Ports:
//   clock        rising-edge system clock
//   reset_n      synchronous active-low reset
//   start        one-cycle run request, honoured in IDLE/DONE/TIMEOUT only
//   mode         enable shaping, latched on accepted start:
//                0 always, 1 periodic stall, 2 LFSR stall, 3 single-step
//   step         single-step request (mode 3 only)
//   pc, halt_pc  core PC and end-of-test address
//   core_reset_n active-low reset to the core
//   enable       core clock enable
//   cycle_count  RUN cycles elapsed in the current run
//   finished     run ended (DONE or TIMEOUT)
//   pass         run ended on a confirmed halt
module run_sequencer_rv32 #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned COUNT_WIDTH  = 32,
  parameter int unsigned RESET_CYCLES = 4,
  parameter int unsigned MAX_CYCLES   = 1000,
  parameter int unsigned STALL_PERIOD = 4,
  parameter int unsigned HALT_CONFIRM = 3,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic                   step,
  input  logic [XLEN-1:0]        pc,
  input  logic [XLEN-1:0]        halt_pc,
  output logic                   core_reset_n,
  output logic                   enable,
  output logic [COUNT_WIDTH-1:0] cycle_count,
  output logic                   finished,
  output logic                   pass
);

  localparam int unsigned HOLD_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int unsigned PHASE_W = $clog2(STALL_PERIOD);
  localparam int unsigned CONF_W  = $clog2(HALT_CONFIRM + 1);

  localparam logic [HOLD_W-1:0]      HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [PHASE_W-1:0]     PHASE_LAST = PHASE_W'(STALL_PERIOD - 1);
  localparam logic [CONF_W-1:0]      CONF_DONE  = CONF_W'(HALT_CONFIRM);
  localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(MAX_CYCLES - 1);
  // An all-zero seed would lock the LFSR, so it is replaced.
  localparam logic [15:0]            SEED       = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET_HOLD,
    S_RUN,
    S_DONE,
    S_TIMEOUT
  } state_t;

  typedef enum logic [1:0] {
    MODE_ALWAYS,
    MODE_PERIODIC,
    MODE_RANDOM,
    MODE_STEP
  } mode_t;

  state_t                 state_q, state_d;
  mode_t                  mode_q, mode_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [PHASE_W-1:0]     phase_q, phase_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic [CONF_W-1:0]      confirm_q, confirm_d;
  logic [COUNT_WIDTH-1:0] cycle_count_q, cycle_count_d;
  logic                   core_reset_n_q, core_reset_n_d;
  logic                   enable_q, enable_d;
  logic                   finished_q, finished_d;
  logic                   pass_q, pass_d;

  logic        pc_match;
  logic        step_en;
  logic [15:0] lfsr_next;

  assign pc_match  = (pc == halt_pc);
  // Fibonacci LFSR, taps 16,14,13,11 in right-shift form.
  assign lfsr_next = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    hold_d        = hold_q;
    phase_d       = phase_q;
    lfsr_d        = lfsr_q;
    confirm_d     = confirm_q;
    cycle_count_d = cycle_count_q;
    step_en       = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_TIMEOUT: begin
        if (start) begin
          state_d       = S_RESET_HOLD;
          mode_d        = mode_t'(mode);
          hold_d        = '0;
          phase_d       = '0;
          lfsr_d        = SEED;
          confirm_d     = '0;
          cycle_count_d = '0;
        end
      end
      S_RESET_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = S_RUN;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_RUN: begin
        // Only cycles the core actually executed count towards the halt.
        if (enable_q) begin
          confirm_d = pc_match ? confirm_q + 1'b1 : '0;
        end
        // Halt is tested first so it wins over a same-cycle timeout.
        if (confirm_d == CONF_DONE) begin
          state_d = S_DONE;
        end else if (cycle_count_q == COUNT_LAST) begin
          state_d = S_TIMEOUT;
        end else begin
          cycle_count_d = cycle_count_q + 1'b1;
          phase_d       = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
          lfsr_d        = lfsr_next;
          step_en       = step;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from next-cycle values:
  // the enable for RUN cycle k is decided at the edge that starts cycle k.
  always_comb begin
    enable_d = 1'b0;
    if (state_d == S_RUN) begin
      case (mode_d)
        MODE_ALWAYS:   enable_d = 1'b1;
        MODE_PERIODIC: enable_d = (phase_d != PHASE_LAST);
        MODE_RANDOM:   enable_d = |lfsr_d[1:0];
        MODE_STEP:     enable_d = step_en;
      endcase
    end
    core_reset_n_d = (state_d == S_RUN) || (state_d == S_DONE) || (state_d == S_TIMEOUT);
    finished_d     = (state_d == S_DONE) || (state_d == S_TIMEOUT);
    pass_d         = (state_d == S_DONE);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      mode_q         <= MODE_ALWAYS;
      hold_q         <= '0;
      phase_q        <= '0;
      lfsr_q         <= SEED;
      confirm_q      <= '0;
      cycle_count_q  <= '0;
      core_reset_n_q <= 1'b0;
      enable_q       <= 1'b0;
      finished_q     <= 1'b0;
      pass_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      hold_q         <= hold_d;
      phase_q        <= phase_d;
      lfsr_q         <= lfsr_d;
      confirm_q      <= confirm_d;
      cycle_count_q  <= cycle_count_d;
      core_reset_n_q <= core_reset_n_d;
      enable_q       <= enable_d;
      finished_q     <= finished_d;
      pass_q         <= pass_d;
    end
  end

  assign core_reset_n = core_reset_n_q;
  assign enable       = enable_q;
  assign cycle_count  = cycle_count_q;
  assign finished     = finished_q;
  assign pass         = pass_q;

endmodule

// File: tb/tb_run_sequencer_rv32.sv
// Testbench for run_sequencer_rv32: directed vector table, hand-written corner
// sequences and randomized traffic against a run-level reference model.
// A second instance built with a zero LFSR seed shares all inputs.
module tb_run_sequencer_rv32;

  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = 32;
  localparam int unsigned RC   = 4;
  localparam int unsigned MAXC = 20;
  localparam int unsigned SP   = 4;
  localparam int unsigned HC   = 3;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            start = 1'b0;
  logic [1:0]      mode = 2'd0;
  logic            step = 1'b0;
  logic [XLEN-1:0] pc = '0;
  logic [XLEN-1:0] halt_pc = 32'h0000_0100;

  logic            core_reset_n, enable, finished, pass;
  logic [CW-1:0]   cycle_count;
  logic            core_reset_n_z, enable_z, finished_z, pass_z;
  logic [CW-1:0]   cycle_count_z;

  always #5 clock = ~clock;

  run_sequencer_rv32 #(
    .XLEN(XLEN), .COUNT_WIDTH(CW), .RESET_CYCLES(RC), .MAX_CYCLES(MAXC),
    .STALL_PERIOD(SP), .HALT_CONFIRM(HC), .LFSR_SEED(16'hACE1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .mode(mode), .step(step),
    .pc(pc), .halt_pc(halt_pc), .core_reset_n(core_reset_n), .enable(enable),
    .cycle_count(cycle_count), .finished(finished), .pass(pass)
  );

  run_sequencer_rv32 #(
    .XLEN(XLEN), .COUNT_WIDTH(CW), .RESET_CYCLES(RC), .MAX_CYCLES(MAXC),
    .STALL_PERIOD(SP), .HALT_CONFIRM(HC), .LFSR_SEED(16'h0000)
  ) dut_z (
    .clock(clock), .reset_n(reset_n), .start(start), .mode(mode), .step(step),
    .pc(pc), .halt_pc(halt_pc), .core_reset_n(core_reset_n_z), .enable(enable_z),
    .cycle_count(cycle_count_z), .finished(finished_z), .pass(pass_z)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_HOLD, M_RUN, M_DONE, M_TIMEOUT} mphase_t;

  mphase_t     m_ph = M_IDLE;
  logic [1:0]  m_mode = 2'd0;
  int unsigned m_held = 0;
  int unsigned m_k = 0;
  int unsigned m_streak = 0;
  logic        e_crn = 1'b0, e_en = 1'b0, e_fin = 1'b0, e_pass = 1'b0;
  int unsigned e_cnt = 0;

  // LFSR state after k advances from the seed.
  function automatic logic [15:0] lfsr_at(input int unsigned k);
    logic [15:0] s;
    s = 16'hACE1;
    for (int unsigned i = 0; i < k; i++) s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    return s;
  endfunction

  function automatic logic run_enable(input logic [1:0] m, input int unsigned k, input logic stepped);
    logic [15:0] s;
    case (m)
      2'd0: return 1'b1;
      2'd1: return (k % SP) != (SP - 1);
      2'd2: begin
        s = lfsr_at(k);
        return |s[1:0];
      end
      default: return stepped;
    endcase
  endfunction

  // Advance the model across one clock edge using the inputs now applied.
  task automatic model_edge();
    if (!reset_n) begin
      m_ph = M_IDLE; m_streak = 0;
      e_crn = 1'b0; e_en = 1'b0; e_cnt = 0; e_fin = 1'b0; e_pass = 1'b0;
    end else begin
      case (m_ph)
        M_IDLE, M_DONE, M_TIMEOUT: if (start) begin
          m_ph = M_HOLD; m_mode = mode; m_held = 1; m_streak = 0;
          e_crn = 1'b0; e_en = 1'b0; e_cnt = 0; e_fin = 1'b0; e_pass = 1'b0;
        end
        M_HOLD: begin
          if (m_held == RC) begin
            m_ph = M_RUN; m_k = 0; e_crn = 1'b1; e_cnt = 0;
            e_en = run_enable(m_mode, 0, 1'b0);
          end else begin
            m_held++;
          end
        end
        default: begin
          if (e_en) m_streak = (pc == halt_pc) ? m_streak + 1 : 0;
          if (m_streak == HC) begin
            m_ph = M_DONE; e_en = 1'b0; e_fin = 1'b1; e_pass = 1'b1;
          end else if (m_k == MAXC - 1) begin
            m_ph = M_TIMEOUT; e_en = 1'b0; e_fin = 1'b1; e_pass = 1'b0;
          end else begin
            m_k++; e_cnt = m_k;
            e_en = run_enable(m_mode, m_k, step);
          end
        end
      endcase
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clock);
    #1;
    chk("core_reset_n", core_reset_n, e_crn);
    chk("enable", enable, e_en);
    chk("cycle_count", cycle_count, e_cnt);
    chk("finished", finished, e_fin);
    chk("pass", pass, e_pass);
    chk("z_core_reset_n", core_reset_n_z, e_crn);
    chk("z_enable", enable_z, e_en);
    chk("z_cycle_count", cycle_count_z, e_cnt);
    chk("z_finished", finished_z, e_fin);
    chk("z_pass", pass_z, e_pass);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; start = 1'b0; step = 1'b0;
    cycle();
    reset_n = 1'b1;
  endtask

  // Returns with RUN cycle 0 on the outputs.
  task automatic start_run(input logic [1:0] m);
    start = 1'b1; mode = m;
    cycle();
    start = 1'b0;
    repeat (RC) cycle();
  endtask

  task automatic run_until_finished(input string name);
    int unsigned n;
    n = 0;
    while (!finished && n < 60) begin
      cycle();
      n++;
    end
    chk({name, "_finished"}, finished, 1'b1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst_n, st;
    logic [1:0]  md;
    logic        stp, match;
    logic        crn, en;
    int unsigned cnt;
    logic        fin, ps;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic s, input logic [1:0] m, input logic st,
                              input logic mt, input logic cr, input logic en,
                              input int unsigned cnt, input logic f, input logic p);
    vec_t v;
    v.rst_n = r; v.st = s; v.md = m; v.stp = st; v.match = mt;
    v.crn = cr; v.en = en; v.cnt = cnt; v.fin = f; v.ps = p;
    return v;
  endfunction

  logic [4:0]  m1_pat = 5'b10111;   // bit k = enable in RUN cycle k, period 4
  logic [5:0]  m2_pat = 6'b110001;  // low two bits of ACE1,5670,AB38,559C,2ACE,1567
  logic        en1 [10];
  int unsigned kk;
  logic        pc_hot;

  initial begin
    // reset, start mode 0, four hold cycles
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0,  0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    // RUN 0..12; start during cycle 2 ignored; pc matches in cycles 10,11,12
    for (int k = 0; k <= 12; k++)
      vecs.push_back(mk(1, k == 3, (k == 3) ? 2'd2 : 2'd0, 0, k >= 11,  1, 1, k, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1,  1, 0, 12, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 1,  1, 0, 12, 1, 1));
    // rerun from DONE in mode 1
    vecs.push_back(mk(1, 1, 1, 0, 0,  0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 1, 0, 0,  0, 0, 0, 0, 0));
    for (int k = 0; k < 5; k++) vecs.push_back(mk(1, 0, 1, 0, 0,  1, m1_pat[k], k, 0, 0));

    foreach (vecs[i]) begin
      reset_n = vecs[i].rst_n; start = vecs[i].st; mode = vecs[i].md; step = vecs[i].stp;
      pc = vecs[i].match ? halt_pc : halt_pc + 32'h4;
      model_edge();
      @(posedge clock);
      #1;
      chk($sformatf("vec%0d_core_reset_n", i), core_reset_n, vecs[i].crn);
      chk($sformatf("vec%0d_enable", i), enable, vecs[i].en);
      chk($sformatf("vec%0d_cycle_count", i), cycle_count, vecs[i].cnt);
      chk($sformatf("vec%0d_finished", i), finished, vecs[i].fin);
      chk($sformatf("vec%0d_pass", i), pass, vecs[i].ps);
      chk($sformatf("vec%0d_z_enable", i), enable_z, vecs[i].en);
    end
    start = 1'b0;

    // mode 1: match straddling the stall cycle (cycles 1..4, stall at 3)
    do_reset();
    start_run(1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("m1_en_k%0d", k), enable, m1_pat[k]);
      pc = (k >= 1) ? halt_pc : halt_pc ^ 32'h10;
      cycle();
    end
    chk("m1_straddle_pass", pass, 1'b1);
    chk("m1_straddle_cnt", cycle_count, 4);

    // mode 0 timeout
    do_reset();
    pc = halt_pc ^ 32'h20;
    start_run(0);
    run_until_finished("timeout");
    chk("timeout_cnt", cycle_count, MAXC - 1);
    chk("timeout_pass", pass, 1'b0);
    chk("timeout_enable", enable, 1'b0);
    chk("timeout_core_reset_n", core_reset_n, 1'b1);

    // mode 3: steps at 2,3,7; matches on the first two enables only
    do_reset();
    start_run(3);
    for (int k = 0; k <= 12; k++) begin
      chk($sformatf("m3_en_k%0d", k), enable, (k == 3) || (k == 4) || (k == 8));
      step = (k == 2) || (k == 3) || (k == 7);
      pc = ((k == 3) || (k == 4)) ? halt_pc : halt_pc ^ 32'h10;
      cycle();
    end
    step = 1'b0;
    run_until_finished("m3");
    chk("m3_no_halt_pass", pass, 1'b0);

    // mode 2 twice, rerun from TIMEOUT
    do_reset();
    pc = halt_pc ^ 32'h40;
    start_run(2);
    for (int k = 0; k < 10; k++) begin
      en1[k] = enable;
      if (k < 6) begin
        chk($sformatf("m2_en_k%0d", k), enable, m2_pat[k]);
        chk($sformatf("m2_z_en_k%0d", k), enable_z, m2_pat[k]);
      end
      cycle();
    end
    run_until_finished("m2_first");
    start_run(2);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("m2_rerun_k%0d", k), enable, en1[k]);
      cycle();
    end
    run_until_finished("m2_second");

    // reset during RUN cycle 5
    do_reset();
    start_run(0);
    repeat (5) cycle();
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    chk("abort_core_reset_n", core_reset_n, 1'b0);
    chk("abort_enable", enable, 1'b0);
    chk("abort_cnt", cycle_count, 0);
    cycle();
    chk("abort_stays_idle", core_reset_n, 1'b0);

    // halt confirmed on the last budget cycle wins over timeout
    start_run(0);
    kk = 0;
    while (!finished && kk < 60) begin
      pc = (kk >= MAXC - HC) ? halt_pc : halt_pc ^ 32'h8;
      cycle();
      kk++;
    end
    chk("tie_pass", pass, 1'b1);
    chk("tie_cnt", cycle_count, MAXC - 1);

    // randomized traffic
    do_reset();
    pc_hot = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      reset_n = ($urandom_range(0, 199) != 0);
      start   = ($urandom_range(0, 19) == 0);
      mode    = 2'($urandom_range(0, 3));
      step    = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 49) == 0) halt_pc = $urandom;
      if ($urandom_range(0, 7) == 0) pc_hot = ~pc_hot;
      pc = pc_hot ? halt_pc : $urandom;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
